// File: rtl/imem_loader.sv
// Boots an instruction memory from a little-endian byte stream, verifies a trailing
// XOR checksum byte, and holds the processor in reset until a clean load completes.
module imem_loader (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] load_len,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [11:0] imem_address,
  output logic [31:0] imem_data,
  output logic        imem_wren,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [11:0] last_idx;
  logic [11:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [7:0]  xor_acc;
  logic        done_r;
  logic        err_r;

  logic [12:0] eff_len;
  logic        accept;

  // Handshake: a byte moves on a rising edge only when rx_valid and rx_ready are
  // both high; rx_ready depends on registered state alone, never on rx_valid.
  assign eff_len = (load_len > 13'd4096) ? 13'd4096 : load_len;
  assign accept  = rx_valid && rx_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      last_idx <= 12'd0;
      word_idx <= 12'd0;
      byte_idx <= 2'd0;
      word     <= 32'd0;
      xor_acc  <= 8'd0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Length 4096 maps to last index 4095, so the word index never wraps.
            last_idx <= 12'(eff_len - 13'd1);
            word_idx <= 12'd0;
            byte_idx <= 2'd0;
            xor_acc  <= 8'd0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            state    <= (eff_len == 13'd0) ? S_CHK : S_RECV;
          end
        end
        S_RECV: begin
          if (accept) begin
            // Shifting in from the top leaves byte 0 in bits 7:0 after four bytes.
            word     <= {rx_data, word[31:8]};
            xor_acc  <= xor_acc ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (word_idx == last_idx) begin
            state <= S_CHK;
          end else begin
            word_idx <= word_idx + 12'd1;
            state    <= S_RECV;
          end
        end
        S_CHK: begin
          if (accept) begin
            err_r  <= (rx_data != xor_acc);
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_ready     = (state == S_RECV) || (state == S_CHK);
  assign imem_wren    = (state == S_WRITE);
  assign imem_address = word_idx;
  assign imem_data    = word;
  assign busy         = (state == S_RECV) || (state == S_WRITE) || (state == S_CHK);
  assign cpu_reset    = !((state == S_DONE) && !err_r);
  assign done         = done_r;
  assign err          = err_r;
  assign state_dbg    = state;

endmodule
